// File: rtl/alu_rr_scheduler_if.sv
// Requester, response and ALU-side signal bundle for alu_rr_scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      alu_start;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [2:0]                alu_mode;
    logic [DATA_W-1:0]         alu_c;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_c,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_start, alu_a, alu_b, alu_mode
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_c,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_start, alu_a, alu_b, alu_mode
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one simple_alu between NUM_REQ requesters.
// Define ALU_SCHED_ACC_EN to make ACC/MAC legal (mode driven only in EXEC).
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    alu_rr_scheduler_if.slave  bus,
    output logic               busy
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_ACC = 3'd5;
    localparam logic [2:0] OP_MAC = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [2:0]          op_q, op_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_mode_q, alu_mode_d;

    logic                found;
    logic [ID_W-1:0]     grant;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [2:0]          sel_op;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic                alu_start_c;

    function automatic logic op_legal(input logic [2:0] op, input logic [DATA_W-1:0] b);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: ok = 1'b1;
            OP_DIV, OP_MOD:         ok = (b != '0);
`ifdef ALU_SCHED_ACC_EN
            OP_ACC, OP_MAC:         ok = 1'b1;
`else
            OP_ACC, OP_MAC:         ok = 1'b0;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Accumulating modes must only be seen by the ALU while it registers (EXEC).
    function automatic logic [2:0] issue_mode(input logic [2:0] op);
`ifdef ALU_SCHED_ACC_EN
        return (op == OP_ACC || op == OP_MAC) ? OP_ADD : op;
`else
        return op;
`endif
    endfunction

    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign sel_a  = bus.req_a[int'(grant)*DATA_W +: DATA_W];
    assign sel_b  = bus.req_b[int'(grant)*DATA_W +: DATA_W];
    assign sel_op = bus.req_op[int'(grant)*3 +: 3];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        err_d       = err_q;
        data_d      = data_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_mode_d  = alu_mode_q;
        req_ready_c = '0;
        alu_start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_c[grant] = 1'b1;
                    id_d     = grant;
                    op_d     = sel_op;
                    rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                    if (op_legal(sel_op, sel_b)) begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_mode_d = issue_mode(sel_op);
                        err_d      = 1'b0;
                        state_d    = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                alu_start_c = 1'b1;
                alu_mode_d  = op_q;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                alu_mode_d = issue_mode(op_q);
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = bus.alu_c;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            op_q       <= OP_ADD;
            err_q      <= 1'b0;
            data_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_mode_q <= OP_ADD;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            err_q      <= err_d;
            data_q     <= data_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.alu_start = alu_start_c;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_mode  = alu_mode_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler with a behavioural simple_alu model.
module tb_alu_rr_scheduler;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_ACC = 3'd5;
    localparam logic [2:0] OP_MAC = 3'd6;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic start_d;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

    alu_rr_scheduler #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus),
        .busy  (busy)
    );

    // ALU: registers c at the end of the cycle following start.
    always @(posedge clk) begin
        start_d <= bus.alu_start;
        if (start_d === 1'b1) begin
            case (bus.alu_mode)
                OP_ADD:  bus.alu_c <= bus.alu_a + bus.alu_b;
                OP_SUB:  bus.alu_c <= bus.alu_a - bus.alu_b;
                OP_MUL:  bus.alu_c <= bus.alu_a * bus.alu_b;
                OP_DIV:  bus.alu_c <= bus.alu_a / bus.alu_b;
                OP_MOD:  bus.alu_c <= bus.alu_a % bus.alu_b;
                OP_ACC:  bus.alu_c <= bus.alu_c + bus.alu_a;
                OP_MAC:  bus.alu_c <= bus.alu_c + bus.alu_a * bus.alu_b;
                default: bus.alu_c <= '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] d, input logic e);
        exp_t x;
        x.id   = 2'(id);
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", bus.rsp_id, e.id);
                chk("rsp_data", bus.rsp_data, e.data);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    // Called at a negedge with the DUT idle and rsp_ready high; returns with it idle again.
    task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e);
        int lat;
        int starts;
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.req_op[id*3 +: 3]  = op;
        bus.req_valid[id]      = 1'b1;
        push_exp(id, exp_d, exp_e);
        #1;
        chk("req_ready_grant", bus.req_ready, 4'b0001 << id);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        bus.req_a[id*32 +: 32] = 32'hDEAD_BEEF;
        bus.req_b[id*32 +: 32] = 32'h0;
        chk("alu_start_after_accept", bus.alu_start, !exp_e);
        lat    = 1;
        starts = 0;
        while (1) begin
            starts += int'(bus.alu_start);
            if (bus.rsp_valid || lat >= 20) break;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_e ? 1 : 4);
        chk("alu_start_count", starts, exp_e ? 0 : 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int cyc;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_alu_start", bus.alu_start, 0);
        chk("reset_alu_mode", bus.alu_mode, OP_ADD);
        chk("reset_alu_a", bus.alu_a, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // All four requesters contend; grants must rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'(i * 10 + 1);
            bus.req_b[i*32 +: 32] = 32'(i + 100);
            bus.req_op[i*3 +: 3]  = OP_ADD;
        end
        for (int i = 0; i < 5; i++)
            push_exp(i % 4, 32'((i % 4) * 10 + 1 + (i % 4) + 100), 1'b0);
        bus.req_valid = 4'hF;
        rc  = 0;
        cyc = 0;
        while (rc < 5 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.rsp_valid) begin
                rc++;
                if (rc == 5) bus.req_valid = '0;
            end
        end
        chk("rr_rsp_count", rc, 5);
        @(negedge clk);

        run_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        run_op(1, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        run_op(3, OP_DIV, 32'd9, 32'd0, 32'd0, 1'b1);
        run_op(2, OP_MUL, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0);
        run_op(3, OP_DIV, 32'd9, 32'd2, 32'd4, 1'b0);
        run_op(3, OP_MOD, 32'd9, 32'd2, 32'd1, 1'b0);
        run_op(1, 3'd7, 32'd1, 32'd1, 32'd0, 1'b1);
`ifdef ALU_SCHED_ACC_EN
        run_op(0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
        run_op(1, OP_ACC, 32'd4, 32'd0, 32'd9, 1'b0);
        run_op(2, OP_MAC, 32'd2, 32'd3, 32'd15, 1'b0);
`else
        run_op(0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
        run_op(1, OP_ACC, 32'd4, 32'd0, 32'd0, 1'b1);
        run_op(2, OP_MAC, 32'd2, 32'd3, 32'd0, 1'b1);
`endif

        // Response stalled for 10 cycles while another requester waits.
        bus.rsp_ready = 1'b0;
        bus.req_a[2*32 +: 32] = 32'd40;
        bus.req_b[2*32 +: 32] = 32'd2;
        bus.req_op[2*3 +: 3]  = OP_ADD;
        bus.req_valid[2]      = 1'b1;
        push_exp(2, 32'd42, 1'b0);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        bus.req_op[2:0]  = OP_ADD;
        bus.req_valid[0] = 1'b1;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_reach_resp", bus.rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_rsp_data", bus.rsp_data, 32'd42);
            chk("stall_req_ready", bus.req_ready, 0);
        end
        bus.req_valid[0] = 1'b0;
        bus.rsp_ready    = 1'b1;
        @(negedge clk);
        chk("stall_release_idle", busy, 0);

        // Reset pulse during EXEC drops the operation and clears rr_ptr.
        bus.req_a[1*32 +: 32] = 32'd1;
        bus.req_b[1*32 +: 32] = 32'd1;
        bus.req_op[1*3 +: 3]  = OP_ADD;
        bus.req_valid[1]      = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_rsp_valid", bus.rsp_valid, 0);
        bus.req_valid = 4'b1001;
        #1;
        chk("post_reset_rr_ptr", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        repeat (6) @(negedge clk);
        chk("post_reset_no_rsp", bus.rsp_valid, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one simple_alu instance between NUM_REQ requesters.
- Round-robin arbitration picks one request and latches its operands and opcode. The block then drives the ALU's start/a/b/mode_select in a fixed ISSUE→EXEC→CAPTURE sequence, samples c, and returns the result to the granted requester on a valid/ready response channel.
- Sits between requester ports and the ALU; it is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width; must match the ALU
- ID_W, $clog2(NUM_REQ), requester index width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*DATA_W  operand a, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand b, same packing
- req_op  in  NUM_REQ*3  opcode per requester (tb_pkg opcode encoding)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester being answered
- rsp_data  out  DATA_W  ALU result
- rsp_err  out  1  request rejected; rsp_data=0
- alu_start  out  1  to ALU start
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_mode  out  3  to ALU mode_select (opcode)
- alu_c  in  DATA_W  from ALU c
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, latched a/b/op/id=0; all outputs 0, alu_mode=ADD.
- Arbitration (IDLE): search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit i wins; req_ready[i]=1 combinationally in that cycle only.
- Handshake and grant: at the edge with req_valid[i]&req_ready[i], latch req_a/b/op slices and id=i, and set rr_ptr=(i+1) mod NUM_REQ.
- Operand stability: requesters may change inputs any time after acceptance; the block uses only latched values.
- FSM states and transitions:
  - IDLE → ISSUE on accept of a legal request.
  - IDLE → RESP directly, err=1, on accept of an illegal request.
  - ISSUE (1 cycle): alu_start=1; alu_a/b/mode = latched values. → EXEC.
  - EXEC (1 cycle): alu_start=0; alu_mode held; ALU registers its result at the end of this cycle. → CAPTURE.
  - CAPTURE (1 cycle): alu_mode held; rsp_data<=alu_c at the end of the cycle. → RESP.
  - RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_ready. On rsp_valid&rsp_ready → IDLE.
- alu_a/alu_b/alu_mode hold their last values outside ISSUE..CAPTURE. alu_start is high only in ISSUE.
- Latency: accept edge to rsp_valid = 4 cycles (IDLE accept, ISSUE, EXEC, CAPTURE; rsp_valid high in the 4th cycle after accept). Throughput is 1 op per 5 cycles at best; no new request is accepted before the RESP handshake completes.
- Illegal requests (rsp_err=1, ALU not started):
  - DIV or MOD with b=0.
  - ACC/MAC when the optional feature is off.
  - Any op encoding outside ADD..MAC.
- Arithmetic: results are exactly the ALU's DATA_W-bit modulo values; no widening.
- rsp_ready held high on entry to RESP: handshake completes in one cycle; IDLE then arbitrates next cycle.
- A requester deasserting req_valid before grant is simply skipped; no fairness debt.
- Reset asserted mid-operation: immediate return to IDLE; any in-flight response is lost; rr_ptr=0.

Optional Feature:
- Macro: ALU_SCHED_ACC_EN
- Defined:
  - ACC and MAC are legal.
  - alu_mode=ACC/MAC is driven only in EXEC, so the ALU accumulates exactly once. In ISSUE and CAPTURE the mode is ADD.
  - rsp_data = previous ALU result + a (ACC) or + a*b (MAC).
  - The previous ALU result is shared across requesters; the block adds no isolation.
- Undefined: ACC/MAC requests complete with rsp_err=1, rsp_data=0, and no ALU start.

Test Plan:
- Reset, then req0 ADD a=5 b=7 → alu_start 1 cycle after accept; rsp_valid 4 cycles after accept; rsp_id=0, rsp_data=12, rsp_err=0.
- req1 SUB a=3 b=5 → rsp_data=32'hFFFF_FFFE. req2 MUL a=32'h10000 b=32'h10000 → rsp_data=0 (wrap).
- All 4 req_valid held high with ADD, rsp_ready=1 → grant order 0,1,2,3,0; each rsp_id matches the grant.
- req3 DIV a=9 b=0 → rsp_err=1, rsp_data=0, alu_start never asserts. DIV a=9 b=2 → 4; MOD a=9 b=2 → 1.
- rsp_ready held low 10 cycles in RESP → rsp_valid/rsp_data stable, all req_ready=0. Reset pulse in EXEC → IDLE next cycle, busy=0, no response.
- With ALU_SCHED_ACC_EN: ADD 2+3 then ACC a=4 → 9; MAC a=2 b=3 → 15. Without the macro: ACC → rsp_err=1.
